// File: rtl/mc_controller_if.sv
// mc_controller_if
// Bundles the signals between the multicycle control unit and its datapath.
//   op, funct   : instruction opcode / R-type function field (from the IR)
//   zero        : ALU zero flag
//   alucontrol  : 4-bit ALU operation code
//   alusrca/b, immsrc, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
//   pcsrc, pcen : datapath selects and enables
// Modports: master = control unit side, slave = datapath side.
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [3:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       immsrc;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic [1:0] pcsrc;
  logic       pcen;

  modport master (
    input  op, funct, zero,
    output alucontrol, alusrca, alusrcb, immsrc, iord, irwrite, memwrite,
           regwrite, regdst, memtoreg, pcsrc, pcen
  );

  modport slave (
    output op, funct, zero,
    input  alucontrol, alusrca, alusrcb, immsrc, iord, irwrite, memwrite,
           regwrite, regdst, memtoreg, pcsrc, pcen
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller
// Multicycle control unit: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select
// and enable, including the ALU operation code.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, returns the FSM to FETCH
//   bus   : mc_controller_if.master (op/funct/zero in, controls out)
// Build option: define BNE_EN to decode opcode 000101 (bne) as a branch
// taken on zero == 0. Without it, 000101 is an unknown opcode.
module mc_controller (
  input  logic               clk,
  input  logic               reset,
  mc_controller_if.master    bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LI    = 6'b010001;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } state_t;

  // How alucontrol is formed in a given state.
  typedef enum logic [2:0] {
    ALU_NONE  = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_FUNCT = 3'd3,
    ALU_IMM   = 3'd4
  } aluop_t;

  // Controls that depend on state alone; rw_gate marks regwrite as
  // conditional on a recognised funct.
  typedef struct packed {
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       rw_gate;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       imm;
    aluop_t     aluop;
  } ctl_t;

  function automatic state_t next_state(state_t s, logic [5:0] op);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:   n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                     n = MEMADR;
          OP_RTYPE:                         n = EXECUTE;
          OP_BEQ:                           n = BRANCH;
`ifdef BNE_EN
          OP_BNE:                           n = BRANCH;
`endif
          OP_J:                             n = JUMP;
          OP_ADDI, OP_XORI, OP_LUI, OP_LI:  n = IMMEX;
          default:                          n = FETCH;
        endcase
      end
      MEMADR:  n = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   n = MEMWB;
      EXECUTE: n = ALUWB;
      IMMEX:   n = IMMWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctl_t decode_state(state_t s);
    ctl_t c;
    c = '0;
    c.aluop = ALU_NONE;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.aluop   = ALU_ADD;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        c.aluop   = ALU_ADD;
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ALU_ADD;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_FUNCT;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.rw_gate  = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      IMMEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ALU_IMM;
        c.imm     = 1'b1;
      end
      IMMWB:   c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c.aluop = ALU_NONE;
    endcase
    return c;
  endfunction

  // {recognised, alucontrol}; unknown funct falls back to add.
  function automatic logic [4:0] funct_decode(logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 4'b0010};
      6'b100010: return {1'b1, 4'b1010};
      6'b100100: return {1'b1, 4'b0000};
      6'b100101: return {1'b1, 4'b0001};
      6'b101010: return {1'b1, 4'b1011};
      6'b000110: return {1'b1, 4'b0110};
      default:   return {1'b0, 4'b0010};
    endcase
  endfunction

  function automatic logic [3:0] imm_decode(logic [5:0] op);
    case (op)
      OP_XORI: return 4'b0100;
      OP_LUI:  return 4'b0101;
      OP_LI:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  state_t     state;
  ctl_t       ctl;
  logic [4:0] fdec;
  logic       taken;
  logic       regwrite_raw;
  logic [3:0] alucontrol;

  // State register; ctl always holds decode_state(state), loaded alongside
  // it so the state-only controls come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctl   <= decode_state(FETCH);
    end else begin
      state <= next_state(state, bus.op);
      ctl   <= decode_state(next_state(state, bus.op));
    end
  end

  assign fdec = funct_decode(bus.funct);

  always_comb begin
    alucontrol = 4'b0000;
    case (ctl.aluop)
      ALU_ADD:   alucontrol = 4'b0010;
      ALU_SUB:   alucontrol = 4'b1010;
      ALU_FUNCT: alucontrol = fdec[3:0];
      ALU_IMM:   alucontrol = imm_decode(bus.op);
      default:   alucontrol = 4'b0000;
    endcase
  end

  // Branch sense: beq takes on zero, bne (when enabled) on ~zero.
  always_comb begin
    taken = bus.zero;
`ifdef BNE_EN
    if (bus.op == OP_BNE) taken = ~bus.zero;
`endif
  end

  assign regwrite_raw = ctl.regwrite & (~ctl.rw_gate | fdec[4]);

  // State-changing enables are held off while reset is asserted, since the
  // async reset only forces the FSM back to FETCH's (enabled) controls.
  assign bus.alucontrol = alucontrol;
  assign bus.alusrca    = ctl.alusrca;
  assign bus.alusrcb    = ctl.alusrcb;
  assign bus.immsrc     = ctl.imm & (bus.op == OP_XORI);
  assign bus.iord       = ctl.iord;
  assign bus.irwrite    = ctl.irwrite & ~reset;
  assign bus.memwrite   = ctl.memwrite & ~reset;
  assign bus.regwrite   = regwrite_raw & ~reset;
  assign bus.regdst     = ctl.regdst;
  assign bus.memtoreg   = ctl.memtoreg;
  assign bus.pcsrc      = ctl.pcsrc;
  assign bus.pcen       = (ctl.pcwrite | (ctl.branch & taken)) & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
// Directed bench for mc_controller: expected control vectors are queued as
// each step is driven and compared when the DUT outputs are sampled.
// Vector layout: {alucontrol[3:0], alusrca, alusrcb[1:0], immsrc, iord,
//                 irwrite, memwrite, regwrite, regdst, memtoreg, pcsrc[1:0], pcen}
module tb_mc_controller;

  typedef logic [16:0] vec_t;

  logic clk = 1'b0;
  logic reset;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  vec_t e_rst, e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr;
  vec_t e_aluwb_ok, e_aluwb_bad, e_immwb, e_jump;

  function automatic vec_t v(logic [3:0] alu, logic a, logic [1:0] b,
                             logic imm, logic iord, logic ir, logic mw,
                             logic rw, logic rd, logic m2r,
                             logic [1:0] pcs, logic pcen);
    return {alu, a, b, imm, iord, ir, mw, rw, rd, m2r, pcs, pcen};
  endfunction

  function automatic vec_t e_exec(logic [3:0] alu);
    return v(alu, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  function automatic vec_t e_branch(logic pcen);
    return v(4'b1010, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, pcen);
  endfunction

  function automatic vec_t e_immex(logic [3:0] alu, logic imm);
    return v(alu, 1'b1, 2'b10, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  function automatic vec_t observed();
    return {bus.alucontrol, bus.alusrca, bus.alusrcb, bus.immsrc, bus.iord,
            bus.irwrite, bus.memwrite, bus.regwrite, bus.regdst, bus.memtoreg,
            bus.pcsrc, bus.pcen};
  endfunction

  task automatic push(input string t, input vec_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check_now();
    vec_t  e;
    vec_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%05h expected=%05h", t, o, e);
    end
  endtask

  // One FSM cycle: queue expectation, sample at the falling edge, then
  // advance past the next rising edge.
  task automatic cyc(input string t, input vec_t e);
    push(t, e);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] imm_ops  [4];
    logic [3:0] imm_alus [4];
    logic       imm_src  [4];

    e_rst       = v(4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    e_fetch     = v(4'b0010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    e_decode    = v(4'b0010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    e_memadr    = v(4'b0010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    e_memrd     = v(4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    e_memwb     = v(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    e_memwr     = v(4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    e_aluwb_ok  = v(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    e_aluwb_bad = v(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    e_immwb     = v(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    e_jump      = v(4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);

    imm_ops  = '{6'b001110, 6'b001111, 6'b010001, 6'b001000};
    imm_alus = '{4'b0100,   4'b0101,   4'b0111,   4'b0010};
    imm_src  = '{1'b1,      1'b0,      1'b0,      1'b0};

    reset     = 1'b1;
    bus.op    = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;

    // Reset held across edges: FETCH selects, enables off
    @(posedge clk);
    @(posedge clk);
    #1;
    push("reset_held", e_rst);
    check_now();
    reset = 1'b0;

    // lw: 5 cycles
    cyc("lw_fetch",  e_fetch);
    cyc("lw_decode", e_decode);
    cyc("lw_memadr", e_memadr);
    cyc("lw_memrd",  e_memrd);
    cyc("lw_memwb",  e_memwb);

    // R-type srlv
    bus.op    = 6'b000000;
    bus.funct = 6'b000110;
    cyc("srlv_fetch",  e_fetch);
    cyc("srlv_decode", e_decode);
    cyc("srlv_exec",   e_exec(4'b0110));
    cyc("srlv_aluwb",  e_aluwb_ok);

    // R-type with unrecognised funct
    bus.funct = 6'b111111;
    cyc("badfn_fetch",  e_fetch);
    cyc("badfn_decode", e_decode);
    cyc("badfn_exec",   e_exec(4'b0010));
    cyc("badfn_aluwb",  e_aluwb_bad);

    // beq taken / not taken
    bus.op    = 6'b000100;
    bus.funct = 6'b000000;
    bus.zero  = 1'b1;
    cyc("beq_z1_fetch",  e_fetch);
    cyc("beq_z1_decode", e_decode);
    cyc("beq_z1_branch", e_branch(1'b1));
    bus.zero = 1'b0;
    cyc("beq_z0_fetch",  e_fetch);
    cyc("beq_z0_decode", e_decode);
    cyc("beq_z0_branch", e_branch(1'b0));

    // Immediate ops
    for (int i = 0; i < 4; i++) begin
      bus.op = imm_ops[i];
      cyc($sformatf("imm%0d_fetch", i),  e_fetch);
      cyc($sformatf("imm%0d_decode", i), e_decode);
      cyc($sformatf("imm%0d_immex", i),  e_immex(imm_alus[i], imm_src[i]));
      cyc($sformatf("imm%0d_immwb", i),  e_immwb);
    end

    // j
    bus.op = 6'b000010;
    cyc("j_fetch",  e_fetch);
    cyc("j_decode", e_decode);
    cyc("j_jump",   e_jump);

    // Unknown opcode: back to FETCH after DECODE
    bus.op = 6'b111111;
    cyc("unk_fetch",  e_fetch);
    cyc("unk_decode", e_decode);

    // bne
    bus.op   = 6'b000101;
    bus.zero = 1'b0;
    cyc("bne_fetch",  e_fetch);
    cyc("bne_decode", e_decode);
`ifdef BNE_EN
    cyc("bne_z0_branch", e_branch(1'b1));
    bus.zero = 1'b1;
    cyc("bne_z1_fetch",  e_fetch);
    cyc("bne_z1_decode", e_decode);
    cyc("bne_z1_branch", e_branch(1'b0));
`endif

    // sw, then async reset while in MEMWR
    bus.op   = 6'b101011;
    bus.zero = 1'b0;
    cyc("sw_fetch",  e_fetch);
    cyc("sw_decode", e_decode);
    cyc("sw_memadr", e_memadr);
    push("sw_memwr", e_memwr);
    check_now();
    #2;
    reset = 1'b1;
    #1;
    push("sw_async_reset", e_rst);
    check_now();
    @(posedge clk);
    #1;
    push("sw_reset_hold", e_rst);
    check_now();
    reset = 1'b0;
    cyc("post_reset_fetch",  e_fetch);
    cyc("post_reset_decode", e_decode);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit that drives the 4-bit `alucontrol` operation code into the datapath ALU and consumes the ALU `zero` flag for branch resolution. It sequences each instruction through fetch, decode, execute, memory and writeback states and emits every datapath select and enable. It sits between the instruction register (`op`, `funct`) and the multicycle datapath.

## Interface
- No parameters.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; forces state to FETCH.
- op  input  6  instruction opcode, instr[31:26].
- funct  input  6  R-type function field, instr[5:0].
- zero  input  1  ALU zero flag; result == 0.
- alucontrol  output  4  ALU operation; bit 3 is invert-b/carry-in, bits [2:0] select the op.
- alusrca  output  1  0 = PC, 1 = register A.
- alusrcb  output  2  00 = register B, 01 = constant 4, 10 = extended imm, 11 = extended imm << 2.
- immsrc  output  1  0 = sign-extend imm, 1 = zero-extend.
- iord  output  1  memory address: 0 = PC, 1 = ALUOut.
- irwrite  output  1  instruction register load.
- memwrite  output  1  data memory write.
- regwrite  output  1  register file write.
- regdst  output  1  destination: 0 = rt, 1 = rd.
- memtoreg  output  1  writeback data: 0 = ALUOut, 1 = memory data.
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pcen  output  1  PC load; pcwrite | (branch & zero).

## Operation
- ALU codes: add 0010, sub 1010, and 0000, or 0001, slt 1011, xor 0100, lui 0101, srlv 0110, pass-b 0111.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, xori 001110, lui 001111, li 010001.
- R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, srlv 000110.
- State register, 4 bits; outputs are decoded from state. `alucontrol` also depends on `op` and `funct`; `pcen` also depends on `zero`. Outputs not listed for a state are 0.
- FETCH: iord 0, alusrca 0, alusrcb 01, alucontrol 0010, pcsrc 00, irwrite 1, pcwrite 1. Next state DECODE.
- DECODE: alusrca 0, alusrcb 11, alucontrol 0010 (branch target into ALUOut).
  - lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; j -> JUMP; addi/xori/lui/li -> IMMEX.
  - Any other opcode -> FETCH (no-op, no writes).
- MEMADR: alusrca 1, alusrcb 10, alucontrol 0010. lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord 1 -> MEMWB.
- MEMWB: regdst 0, memtoreg 1, regwrite 1 -> FETCH.
- MEMWR: iord 1, memwrite 1 -> FETCH.
- EXECUTE: alusrca 1, alusrcb 00, alucontrol from funct -> ALUWB. Unrecognised funct gives alucontrol 0010.
- ALUWB: regdst 1, memtoreg 0, regwrite 1 only if funct is recognised, else 0 -> FETCH.
- BRANCH: alusrca 1, alusrcb 00, alucontrol 1010, pcsrc 01, branch 1 -> FETCH.
- IMMEX: alusrca 1, alusrcb 10. alucontrol: addi 0010, xori 0100, lui 0101, li 0111. immsrc is 1 for xori, otherwise 0. Next state IMMWB.
- IMMWB: regdst 0, memtoreg 0, regwrite 1 -> FETCH.
- JUMP: pcsrc 10, pcwrite 1 -> FETCH.

## Timing
- Cycles per instruction, counted from FETCH:
  - lw 5
  - sw, R-type, addi, xori, lui, li 4
  - beq, j 3
  - unknown opcode 2
- State updates on the rising edge of clk. Reset asynchronously clears state to FETCH with no clock needed.
- While reset is high, pcen, irwrite, regwrite and memwrite are forced to 0. Other outputs take their FETCH values.
- Reset deasserted: the first rising edge executes FETCH, asserting irwrite and pcen.
- Reset mid-instruction abandons the instruction: no partial writeback, and the next cycle is FETCH.
- `zero` is sampled combinationally in BRANCH only. zero = 1 asserts pcen that cycle; zero = 0 leaves the PC unchanged.

## Configuration
- BNE_EN defined: opcode 000101 (bne) is decoded to BRANCH with alucontrol 1010. pcen = branch & ~zero for bne.
- BNE_EN undefined: 000101 is treated as an unknown opcode and returns to FETCH after DECODE with no writes.

## Test plan
- Reset held, then released with op = 100011 (lw): state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. memtoreg = 1 and regwrite = 1 in cycle 5 only.
- R-type with funct 000110 (srlv): alucontrol = 0110 in EXECUTE, regdst = 1 and regwrite = 1 in ALUWB. With funct 111111: regwrite = 0 in ALUWB.
- beq with zero = 1: pcen = 1 and pcsrc = 01 in cycle 3. With zero = 0: pcen = 0 and the next state is FETCH.
- IMMEX sweep:
  - op 001110 -> alucontrol 0100, immsrc 1
  - op 001111 -> alucontrol 0101
  - op 010001 -> alucontrol 0111
  - op 001000 -> alucontrol 0010
- Assert reset asynchronously during MEMWR (memwrite = 1): memwrite drops to 0 before the next clock, and state is FETCH after release.
- Drive op 000101: with BNE_EN and zero = 0, pcen = 1 in BRANCH. Without BNE_EN, the sequence is FETCH, DECODE, FETCH with no enables raised in DECODE.
